// File: rtl/test_ctrl_pkg.sv
// test_ctrl_pkg: controller states, register offsets and STATUS bit positions.
package test_ctrl_pkg;
  typedef enum logic [2:0] {
    HOLD, RUN, PASS, FAIL
`ifdef TEST_CTRL_WDOG_EN
    , TOUT
`endif
  } state_t;
  localparam logic [7:0] TOHOST_ADDR = 8'h00;
  localparam logic [7:0] STATUS_ADDR = 8'h04;
  localparam logic [7:0] CYCLES_ADDR = 8'h08;
  localparam logic [7:0] RESULT_ADDR = 8'h10;
  localparam int DONE_BIT = 0;
  localparam int PASS_BIT = 1;
  localparam int TOUT_BIT = 2;
endpackage

// File: rtl/test_ctrl_rst_seq.sv
// rst_seq: holds core_rst for RST_CYCLES cycles once rst is seen low; go marks the last held cycle.
module rst_seq #(
  parameter int RST_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic core_rst,
  output logic go
);
  localparam int W = $clog2(RST_CYCLES + 2);
  localparam logic [W-1:0] LAST = W'(RST_CYCLES);
  localparam logic [W-1:0] DONE = W'(RST_CYCLES + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (cnt != DONE) cnt <= cnt + 1'b1;
  assign core_rst = cnt != DONE;
  assign go = cnt == LAST;
endmodule

// File: rtl/test_ctrl.sv
// test_ctrl: test-harness controller with TOHOST/STATUS/CYCLES/RESULT registers; TEST_CTRL_WDOG_EN enables the watchdog.
module test_ctrl
  import test_ctrl_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int TIMEOUT    = 300,
  parameter int CNT_W      = 16,
  parameter int RST_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        core_rst_o,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [30:0] fail_code_o
);
  state_t state, nxt;
  logic go, wr, tohost_wr;
  logic [31:0] rd;
  logic [31:0] result [N_CH];
  rst_seq #(.RST_CYCLES(RST_CYCLES)) u_seq (.clk(clk_i), .rst(rst_i), .core_rst(core_rst_o), .go(go));
  assign wr = req_i && we_i && state == RUN;
  assign tohost_wr = wr && addr_i == TOHOST_ADDR && wdata_i != 32'd0;
`ifdef TEST_CTRL_WDOG_EN
  logic [CNT_W-1:0] cycles;
  always_ff @(posedge clk_i)
    if (rst_i) cycles <= '0;
    else if (state == RUN && cycles != '1) cycles <= cycles + 1'b1;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT, CNT_W};
  assign timeout_o = 1'b0;
`endif
  always_comb begin
    nxt = state;
    if (state == HOLD && go) nxt = RUN;
    else if (state == RUN) begin
      if (tohost_wr) nxt = wdata_i == 32'd1 ? PASS : FAIL;
`ifdef TEST_CTRL_WDOG_EN
      else if (cycles == CNT_W'(TIMEOUT - 1)) nxt = TOUT;
`endif
    end
  end
  always_ff @(posedge clk_i) begin
    state <= rst_i ? HOLD : nxt;
    done_o <= !rst_i && nxt != HOLD && nxt != RUN;
    pass_o <= !rst_i && nxt == PASS;
`ifdef TEST_CTRL_WDOG_EN
    timeout_o <= !rst_i && nxt == TOUT;
`endif
    if (rst_i) fail_code_o <= '0;
    else if (state == RUN && nxt == FAIL) fail_code_o <= wdata_i[31:1];
  end
  always_ff @(posedge clk_i)
    for (int i = 0; i < N_CH; i++)
      if (rst_i) result[i] <= '0;
      else if (wr && addr_i == RESULT_ADDR + 8'(4 * i)) result[i] <= wdata_i;
  always_comb begin
    rd = '0;
    if (addr_i == STATUS_ADDR) begin
      rd[DONE_BIT] = done_o;
      rd[PASS_BIT] = pass_o;
      rd[TOUT_BIT] = timeout_o;
    end
`ifdef TEST_CTRL_WDOG_EN
    if (addr_i == CYCLES_ADDR) rd = 32'(cycles);
`endif
    for (int i = 0; i < N_CH; i++)
      if (addr_i == RESULT_ADDR + 8'(4 * i)) rd = result[i];
  end
  always_ff @(posedge clk_i) begin
    ack_o <= !rst_i && req_i;
    rdata_o <= (!rst_i && req_i && !we_i) ? rd : '0;
  end
endmodule
